// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions (receive FSM states, default bit timing)
// Contents:
//   uart_rx_state_t   receive FSM state encoding; PARITY exists in every build
//   CLKS_PER_BIT_DEF  default clocks per bit (50 MHz / 115200 baud)
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    localparam int CLKS_PER_BIT_DEF = 434;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input
// Ports:
//   clk  input   sampling clock
//   rst  input   asynchronous active-high reset, both flops load RESET_VAL
//   d_i  input   asynchronous input
//   q_o  output  synchronized copy of d_i, two cycles late
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with single-entry holding register and error pulses
// Optional feature macro: UART_RX_PARITY_EN (adds an even parity bit and parity_err)
// Ports:
//   clk        input   system clock
//   rst        input   asynchronous active-high reset
//   rx         input   serial line, idles high, asynchronous to clk
//   rx_ready   input   consumer takes rx_data this cycle
//   rx_data    output  received byte, first bit on the wire is the LSB
//   rx_valid   output  rx_data holds an unread byte
//   busy       output  a frame is in progress
//   frame_err  output  one-cycle pulse, stop bit sampled low
//   overrun    output  one-cycle pulse, good byte dropped because holding register full
//   parity_err output  one-cycle pulse, parity mismatch (UART_RX_PARITY_EN only)
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 overrun
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    logic                 rx_s;
    uart_rx_state_t       state_q;
    logic [TW-1:0]        timer_q;
    logic [IW-1:0]        idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic                 frame_good_d;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d_i(rx),
        .q_o(rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bit_q;
    logic parity_err_q;
    logic par_bad_d;

    // Even parity: data bits plus parity bit must hold an even number of ones.
    assign par_bad_d    = (^shift_q) ^ par_bit_q;
    assign frame_good_d = rx_s && !par_bad_d;
`else
    assign frame_good_d = rx_s;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            // Consumer drain; a load from a completing frame below overrides it.
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        timer_q <= '0;
                    end
                end

                START: begin
                    if (timer_q == HALF_LAST) begin
                        timer_q <= '0;
                        idx_q   <= '0;
                        // A line already back high at mid start bit was a glitch.
                        state_q <= rx_s ? IDLE : DATA;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end

                DATA: begin
                    if (timer_q == BIT_LAST) begin
                        timer_q        <= '0;
                        shift_q[idx_q] <= rx_s;
                        if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end

                PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (timer_q == BIT_LAST) begin
                        timer_q   <= '0;
                        par_bit_q <= rx_s;
                        state_q   <= STOP;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
`else
                    state_q <= IDLE;
`endif
                end

                STOP: begin
                    // Sampling mid stop bit and leaving at once keeps the
                    // second half of the stop bit free to catch a new start edge.
                    if (timer_q == BIT_LAST) begin
                        timer_q     <= '0;
                        state_q     <= IDLE;
                        frame_err_q <= !rx_s;
`ifdef UART_RX_PARITY_EN
                        parity_err_q <= par_bad_d;
`endif
                        if (frame_good_d) begin
                            if (!rx_valid_q || rx_ready) begin
                                rx_data_q  <= shift_q;
                                rx_valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive end of the CPU's UART link: recovers 8N1 frames (8 data bits, no parity, 1 stop bit) from the `rx` pin.
- Delivers each byte to the core's memory-mapped UART register bank over a valid/ready handshake.
- Single-entry holding register; framing and overrun errors reported as one-cycle pulses.
- Sits between the top-level pin and the load/store path; the core drains bytes through `rx_ready`.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200 baud); legal range ≥ 4.
- DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- rx  input  1  serial line, idles high, asynchronous to clk.
- rx_ready  input  1  consumer accepts rx_data this cycle.
- rx_data  output  DATA_BITS  received byte, LSB is the first bit on the wire.
- rx_valid  output  1  rx_data holds an unread byte.
- busy  output  1  a frame is in progress (state ≠ IDLE).
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: completed byte dropped because the holding register was full.

Behaviour:
- Reset:
  - One clock `clk`; reset `rst` is asynchronous and active-high.
  - On reset: rx_data=0, rx_valid=0, busy=0, frame_err=0, overrun=0; state=IDLE; counters=0; synchronizer flops=1.
- Input synchronizer:
  - `rx` passes through 2 flops (rx_s) before any use, giving 2 cycles of input latency.
- Counters:
  - Bit-timer width is $clog2(CLKS_PER_BIT); bit index width is $clog2(DATA_BITS).
  - All comparisons are unsigned; the timer reloads to 0 on each bit boundary.
- FSM states and transitions:
  - IDLE: on rx_s==0, go to START with timer=0.
  - START: when timer==CLKS_PER_BIT/2-1 (integer divide), sample rx_s.
    - rx_s==0: go to DATA, timer=0, index=0.
    - rx_s==1: treat as a glitch and return to IDLE; no error is flagged.
  - DATA: when timer==CLKS_PER_BIT-1, shift rx_s into shift[index]; increment index.
    - After index DATA_BITS-1, go to STOP.
  - STOP: when timer==CLKS_PER_BIT-1, sample rx_s and go directly to IDLE in the same cycle.
    - This is about mid stop bit, so a back-to-back start edge is caught.
    - rx_s==1: good frame.
    - rx_s==0: frame_err pulses the next cycle; the byte is discarded and rx_valid/rx_data are unchanged.
- Handshake:
  - On a good frame:
    - rx_valid==0, or rx_valid==1 with rx_ready==1 in the same cycle: load rx_data; rx_valid=1 the next cycle.
    - rx_valid==1 and rx_ready==0: new byte dropped, old byte kept, overrun pulses.
  - rx_valid falls the cycle after rx_valid&&rx_ready, unless a new byte loads in that same cycle.
  - rx_ready while rx_valid==0 has no effect.
  - rx_data is stable while rx_valid==1 and no load occurs.
- Latency:
  - rx_valid asserts 1 cycle after the STOP sample, which is ~(DATA_BITS+1.5)*CLKS_PER_BIT + 3 cycles after the falling start edge on the pin.
- Line behaviour:
  - rx held low indefinitely: frame_err once per frame time.
  - The FSM restarts as soon as rx_s==0 is seen in IDLE; there is no extra idle requirement.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, sampled at CLKS_PER_BIT-1.
  - Even parity over the data bits.
  - Adds output `parity_err` (1 bit, one-cycle pulse, reset 0), pulsing with the STOP outcome.
  - A byte with bad parity is discarded, same as a framing error.
  - Frame length becomes DATA_BITS+3 bits.
- Undefined:
  - No PARITY state and no parity_err port; 8N1 only.

Decomposition:
- Package `uart_pkg`:
  - State enum uart_rx_state_t {IDLE, START, DATA, PARITY, STOP}; PARITY is present even when unused.
  - Localparam default CLKS_PER_BIT_DEF=434.
  - Shared with the TX block.
- Sub-module `sync_2ff`: the 2-flop synchronizer, async active-high reset, reset value parameterised (1 here).
- The FSM, timer and holding register stay in uart_rx.

Test Plan (CLKS_PER_BIT=16, DATA_BITS=8):
1. Drive 0xA5 frame, rx_ready=0 → rx_valid=1 with rx_data=0xA5 about 155 cycles after the start edge; busy low after the stop sample; no error pulses.
2. Start-bit glitch: rx low for 4 cycles, then high → back to IDLE, busy falls, no rx_valid and no frame_err.
3. 0x3C frame with stop bit driven 0 → single frame_err pulse; rx_valid stays 0; the next good 0x81 frame is received correctly.
4. Send 0x11 and leave it unread, then send 0x22 → overrun pulse; rx_data stays 0x11. Repeat with rx_ready=1 on the load cycle → rx_data=0x22, rx_valid stays 1.
5. Back-to-back frames 0x00, 0xFF with no idle gap, drained every byte → both received in order; no errors.
6. Assert rst for 1 cycle mid-DATA → all outputs 0 asynchronously; the next full 0x5A frame is received correctly. With UART_RX_PARITY_EN, 0x5A with parity bit 1 → parity_err pulse and no rx_valid.
